// File: rtl/led_flow_pkg.sv
// led_flow_pkg: shared types and helpers for the LED flow controller.
//   mode_e    : display mode, encoding matches the mode_o port
//   dir_e     : bounce direction
//   LED_W_DEF : default LED count
//   ms2cyc()  : milliseconds to clock cycles at a given clock frequency
package led_flow_pkg;

  typedef enum logic [1:0] {
    SHIFT_L = 2'd0,
    SHIFT_R = 2'd1,
    BOUNCE  = 2'd2,
    BLINK   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_e;

  localparam int unsigned LED_W_DEF = 6;

  function automatic int unsigned ms2cyc(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/led_flow_ctrl_key_debounce.sv
// key_debounce: synchronizes an asynchronous active-low push-button, debounces it
// and emits a one-cycle pulse on each debounced press (1->0). Release and holding
// produce nothing.
// Ports:
//   sys_clk  in  clock, rising edge
//   sys_set  in  asynchronous active-high reset
//   key_n    in  raw button, active low, asynchronous
//   press    out one-cycle pulse per debounced press
module key_debounce
  import led_flow_pkg::*;
#(
  parameter int unsigned DEB_CYC = 540_000
) (
  input  logic sys_clk,
  input  logic sys_set,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [1:0]    r_sync;
  logic          r_prev;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the synchronized level is steady and differs from
  // the debounced level; any change of the raw sample restarts it.
  always_ff @(posedge sys_clk or posedge sys_set) begin
    if (sys_set) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_db   <= 1'b1;
      r_db_d <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], key_n};
      r_prev <= r_sync[1];
      r_db_d <= r_db;
      if ((r_sync[1] != r_prev) || (r_sync[1] == r_db)) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC - 1)) begin
        r_db  <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_db_d & ~r_db;

endmodule

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: LED pattern generator for the board led bus feeding the analyzer.
// A prescaler produces a step tick; a debounced button cycles four display modes
// (SHIFT_L, SHIFT_R, BOUNCE, BLINK); the pattern advances once per tick.
// Ports:
//   sys_clk  in  clock, rising edge
//   sys_set  in  asynchronous active-high reset
//   key_n    in  mode button, active low, asynchronous
//   led      out LED drive, active low
//   step_o   out one-cycle pulse per pattern step (analyzer trigger)
//   mode_o   out current mode
// Build option: define LED_PWM_EN to add an 8-bit PWM dimmer (parameter DUTY/256).
module led_flow_ctrl
  import led_flow_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 27_000_000,
  parameter int unsigned STEP_MS = 250,
  parameter int unsigned DEB_MS  = 20,
  parameter int unsigned LED_W   = LED_W_DEF
`ifdef LED_PWM_EN
  ,
  parameter int unsigned DUTY    = 64
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_set,
  input  logic             key_n,
  output logic [LED_W-1:0] led,
  output logic             step_o,
  output logic [1:0]       mode_o
);

  localparam int unsigned STEP_CYC = ms2cyc(CLK_HZ, STEP_MS);
  localparam int unsigned DEB_CYC  = ms2cyc(CLK_HZ, DEB_MS);
  localparam int unsigned PW       = $clog2(STEP_CYC);

  mode_e            r_mode, w_mode_nxt;
  dir_e             r_dir, w_dir_nxt;
  logic [LED_W-1:0] r_pat, w_pat_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic             r_step, w_step_nxt;
  logic             w_tick;
  logic             w_press;

  key_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_key (
    .sys_clk(sys_clk),
    .sys_set(sys_set),
    .key_n  (key_n),
    .press  (w_press)
  );

  assign w_tick = (r_presc == PW'(STEP_CYC - 1));

  always_ff @(posedge sys_clk or posedge sys_set) begin
    if (sys_set) begin
      r_mode  <= SHIFT_L;
      r_dir   <= DIR_L;
      r_pat   <= LED_W'(1);
      r_presc <= '0;
      r_step  <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_dir   <= w_dir_nxt;
      r_pat   <= w_pat_nxt;
      r_presc <= w_presc_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // A press takes priority over a coincident tick: the tick and its step_o pulse
  // are discarded and the new mode starts from a cleared prescaler.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_dir_nxt   = r_dir;
    w_pat_nxt   = r_pat;
    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
    w_step_nxt  = w_tick;
    if (w_press) begin
      w_presc_nxt = '0;
      w_step_nxt  = 1'b0;
      w_dir_nxt   = DIR_L;
      case (r_mode)
        SHIFT_L: w_mode_nxt = SHIFT_R;
        SHIFT_R: w_mode_nxt = BOUNCE;
        BOUNCE:  w_mode_nxt = BLINK;
        default: w_mode_nxt = SHIFT_L;
      endcase
      w_pat_nxt = (w_mode_nxt == BLINK) ? '1 : LED_W'(1);
    end else if (w_tick) begin
      case (r_mode)
        SHIFT_L: w_pat_nxt = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
        SHIFT_R: w_pat_nxt = {r_pat[0], r_pat[LED_W-1:1]};
        BOUNCE: begin
          // Turn around on arrival at an end so that end LED is held for one step only.
          if (r_dir == DIR_L) begin
            w_pat_nxt = r_pat << 1;
            if (w_pat_nxt[LED_W-1]) w_dir_nxt = DIR_R;
          end else begin
            w_pat_nxt = r_pat >> 1;
            if (w_pat_nxt[0]) w_dir_nxt = DIR_L;
          end
        end
        default: w_pat_nxt = ~r_pat;
      endcase
    end
  end

  assign step_o = r_step;
  assign mode_o = r_mode;

`ifdef LED_PWM_EN
  logic [7:0] r_pwm;
  logic       w_pwm_on;

  always_ff @(posedge sys_clk or posedge sys_set) begin
    if (sys_set) r_pwm <= '0;
    else         r_pwm <= r_pwm + 8'd1;
  end

  assign w_pwm_on = (r_pwm < 8'(DUTY));
  assign led      = ~(r_pat & {LED_W{w_pwm_on}});
`else
  assign led = ~r_pat;
`endif

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Self-checking bench for led_flow_ctrl with STEP_CYC=4 and DEB_CYC=2.
module tb_led_flow_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_set;
  logic       key_n;
  logic [5:0] led;
  logic       step_o;
  logic [1:0] mode_o;

  always #5 sys_clk = ~sys_clk;

  led_flow_ctrl #(
    .CLK_HZ (1000),
    .STEP_MS(4),
    .DEB_MS (2),
    .LED_W  (6)
  ) dut (
    .sys_clk(sys_clk),
    .sys_set(sys_set),
    .key_n  (key_n),
    .led    (led),
    .step_o (step_o),
    .mode_o (mode_o)
  );

  typedef struct {
    logic [5:0] led;
    logic       step;
    logic [1:0] mode;
  } exp_t;

  typedef struct {
    logic [5:0] led;
    logic       step;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   rel   = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
    rel++;
  endtask

  // Expected active-high pattern k clock edges after a mode entry.
  function automatic logic [5:0] exp_pat(input int m, input int k);
    int         n;
    int         idx;
    logic [5:0] p;
    n = k / 4;
    p = 6'b000001;
    case (m)
      0: for (int i = 0; i < n; i++) p = {p[4:0], p[5]};
      1: for (int i = 0; i < n; i++) p = {p[0], p[5:1]};
      2: begin
        idx = n % 10;
        if (idx > 5) idx = 10 - idx;
        p = 6'b000001 << idx;
      end
      default: p = (n % 2 == 0) ? 6'b111111 : 6'b000000;
    endcase
    return p;
  endfunction

  task automatic track(input int m, input int n, input int rel_release);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (rel == rel_release) key_n = 1'b1;
      e.led  = ~exp_pat(m, rel + 1);
      e.step = ((rel + 1) % 4 == 0);
      e.mode = 2'(m);
      sb.push_back(e);
      cyc();
      e = sb.pop_front();
      chk($sformatf("led m%0d k%0d", m, rel), led, e.led);
      chk($sformatf("step m%0d k%0d", m, rel), step_o, e.step);
      chk($sformatf("mode m%0d k%0d", m, rel), mode_o, e.mode);
    end
  endtask

  task automatic press(input logic [1:0] target, output int lat);
    key_n = 1'b0;
    lat   = 0;
    while (mode_o != target && lat < 40) begin
      cyc();
      lat++;
    end
    total++;
    if (mode_o != target) begin
      bad++;
      $display("FAIL press_to_%0d: mode got %0d expected %0d after %0d cycles", target, mode_o, target, lat);
    end
    rel = 0;
    chk($sformatf("entry_led_%0d", target), led, (target == 2'd3) ? 6'b000000 : 6'b111110);
    chk($sformatf("entry_step_%0d", target), step_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[24];
    logic [5:0] pats[7];
    int         nstep;
    int         lat;
    int         lat2;
    int         c;
    int         lit;

    pats = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111, 6'b111110};
    for (int k = 1; k <= 24; k++) begin
      vt[k-1].led  = pats[k/4];
      vt[k-1].step = (k % 4 == 0);
    end

    sys_set = 1'b1;
    key_n   = 1'b1;
    repeat (3) cyc();
    chk("reset_led", led, 6'b111110);
    chk("reset_step", step_o, 1'b0);
    chk("reset_mode", mode_o, 2'd0);
    sys_set = 1'b0;
    rel     = 0;

    // Free-running SHIFT_L after reset
    nstep = 0;
    for (int i = 0; i < 24; i++) begin
      exp_t e;
      e.led  = vt[i].led;
      e.step = vt[i].step;
      e.mode = 2'd0;
      sb.push_back(e);
      cyc();
      e = sb.pop_front();
      if (step_o === 1'b1) nstep++;
      chk($sformatf("t1_led k%0d", i + 1), led, e.led);
      chk($sformatf("t1_step k%0d", i + 1), step_o, e.step);
    end
    chk("t1_step_count", nstep, 6);

    // Clean press: SHIFT_L -> SHIFT_R
    press(2'd1, lat);
    key_n = 1'b1;
    track(1, 12, -1);

    // Bouncing key then held low: one press only, no repeat while held
    key_n = 1'b0; cyc();
    key_n = 1'b1; cyc();
    press(2'd2, lat);
    track(2, 48, 20);

    // BLINK, then a press landing on a tick edge
    press(2'd3, lat);
    track(3, 12, 0);
    c = 12;
    while ((c + lat) % 4 != 0) c++;
    track(3, c - 12, -1);
    key_n = 1'b0;
    track(3, lat - 1, -1);
    lat2 = 0;
    cyc();
    chk("tickpress_mode", mode_o, 2'd0);
    chk("tickpress_led", led, 6'b111110);
    chk("tickpress_step", step_o, 1'b0);
    rel = 0;
    track(0, 12, 1);

    // Reset asserted mid-count in BOUNCE
    press(2'd1, lat2);
    key_n = 1'b1;
    track(1, 12, -1);
    press(2'd2, lat2);
    key_n = 1'b1;
    track(2, 6, -1);
    sys_set = 1'b1;
    #1;
    chk("midreset_led", led, 6'b111110);
    chk("midreset_step", step_o, 1'b0);
    chk("midreset_mode", mode_o, 2'd0);
    cyc();
    chk("inreset_led", led, 6'b111110);
    sys_set = 1'b0;
    rel     = 0;
    track(0, 8, -1);

    // LED on-time over one full PWM period
    lit = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (led != 6'b111111) lit++;
    end
`ifdef LED_PWM_EN
    chk("pwm_on_cycles", lit, 64);
`else
    chk("pwm_on_cycles", lit, 256);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
